// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU SRAM-to-AXI3 bridge.
package cpu_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 3;

  localparam logic [ID_W-1:0] ID_INST_C  = 4'd0;
  localparam logic [ID_W-1:0] ID_DATA_C  = 4'd1;
  localparam logic [1:0]      FETCH_SIZE = 2'd2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_WAIT
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } w_state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } ar_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } aw_req_t;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU inst/data SRAM-like ports onto one AXI3 master port with
// one outstanding read and one outstanding write, all single-beat.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_C,
  parameter logic [3:0] ID_DATA = ID_DATA_C
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  r_state_e r_state_q;
  w_state_e w_state_q;
  ar_req_t  ar_q;
  aw_req_t  aw_q;
  logic     arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  logic r_idle, w_idle, data_rd_req, data_wr_req;
  logic acc_data_rd, acc_data_wr, acc_fetch;
  logic r_fire, b_fire, aw_done, w_done;

  // Accept logic: data reads need both FSMs idle and beat fetches; data
  // writes need both idle so data-side reads and writes never overlap.
  assign r_idle      = (r_state_q == R_IDLE);
  assign w_idle      = (w_state_q == W_IDLE);
  assign data_rd_req = data_sram_req & ~data_sram_wr;
  assign data_wr_req = data_sram_req &  data_sram_wr;
  assign acc_data_rd = resetn & r_idle & w_idle & data_rd_req;
  assign acc_data_wr = resetn & r_idle & w_idle & data_wr_req;
  assign acc_fetch   = resetn & r_idle & inst_sram_req & ~acc_data_rd & ~data_rd_req | 
                       resetn & r_idle & inst_sram_req & data_rd_req & ~w_idle;

  assign inst_sram_addr_ok = acc_fetch;
  assign data_sram_addr_ok = acc_data_rd | acc_data_wr;

  assign r_fire = resetn & rready_q & rvalid;
  assign b_fire = resetn & bready_q & bvalid;

  assign inst_sram_data_ok = r_fire & (rid == ID_INST);
  assign data_sram_data_ok = (r_fire & (rid == ID_DATA)) | b_fire;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arsize  = ar_q.size;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = aw_q.addr;
  assign awsize  = aw_q.size;
  assign awvalid = awvalid_q;
  assign wdata   = aw_q.data;
  assign wstrb   = aw_q.strb;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Read FSM: latch one request, present AR, then wait for the single R beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (acc_data_rd) begin
            ar_q      <= '{id: ID_DATA, addr: data_sram_addr, size: {1'b0, data_sram_size}};
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end else if (acc_fetch) begin
            ar_q      <= '{id: ID_INST, addr: inst_sram_addr, size: {1'b0, FETCH_SIZE}};
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rvalid) begin
            rready_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q  | wready;

  // Write FSM: AW and W launch together and retire independently before B.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (acc_data_wr) begin
            aw_q      <= '{addr: data_sram_addr, size: {1'b0, data_sram_size},
                           data: data_sram_wdata, strb: data_sram_wstrb};
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= W_REQ;
          end
        end
        W_REQ: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed self-checking bench for cpu_axi_bridge; the bench plays the AXI
// slave cycle by cycle and checks both SRAM-side and AXI-side timing.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int passed;
  int total;

  cpu_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arsize            (arsize),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rvalid            (rvalid),
    .rready            (rready),
    .awaddr            (awaddr),
    .awsize            (awsize),
    .awvalid           (awvalid),
    .awready           (awready),
    .wdata             (wdata),
    .wstrb             (wstrb),
    .wvalid            (wvalid),
    .wready            (wready),
    .bvalid            (bvalid),
    .bready            (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_sram_req   = 1'b0;
    inst_sram_addr  = 32'h0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    arready = 1'b0;
    rid     = 4'h0;
    rdata   = 32'h0;
    rvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    inst_sram_req = 1'b1;
    inst_sram_addr = 32'h1c00_0000;
    cyc();
    cyc();
    smp();
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0)
      $display("FAIL reset_valids: got %b exp 00000", {arvalid, rready, awvalid, wvalid, bready});
    else passed++;
    total++;
    if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0)
      $display("FAIL reset_oks: got %b exp 0000",
               {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    else passed++;
    total++;
    if ({arid, araddr, arsize, awaddr, awsize, wdata, wstrb} !== 110'b0)
      $display("FAIL reset_regs: got araddr=%h awaddr=%h wdata=%h exp 0", araddr, awaddr, wdata);
    else passed++;
    cyc();
    idle_inputs();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_fetch();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0000;
    smp();
    total++;
    if ({inst_sram_addr_ok, arvalid} !== 2'b10)
      $display("FAIL fetch_c0: got addr_ok/arvalid=%b exp 10", {inst_sram_addr_ok, arvalid});
    else passed++;
    cyc();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    smp();
    total++;
    if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'h1c00_0000, 4'd0, 3'd2})
      $display("FAIL fetch_ar: got v=%b addr=%h id=%h size=%h exp 1 1c000000 0 2",
               arvalid, araddr, arid, arsize);
    else passed++;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd0;
    rdata = 32'h0280_0c0c;
    smp();
    total++;
    if ({rready, inst_sram_data_ok, data_sram_data_ok, arvalid} !== 4'b1100)
      $display("FAIL fetch_r_flags: got %b exp 1100",
               {rready, inst_sram_data_ok, data_sram_data_ok, arvalid});
    else passed++;
    total++;
    if (inst_sram_rdata !== 32'h0280_0c0c)
      $display("FAIL fetch_rdata: got %h exp 02800c0c", inst_sram_rdata);
    else passed++;
    cyc();
    idle_inputs();
    smp();
    total++;
    if ({rready, arvalid, inst_sram_data_ok} !== 3'b0)
      $display("FAIL fetch_done: got %b exp 000", {rready, arvalid, inst_sram_data_ok});
    else passed++;
    cyc();
  endtask

  task automatic test_read_priority();
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_size = 2'd1;
    data_sram_addr = 32'h0000_0200;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0004;
    smp();
    total++;
    if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10)
      $display("FAIL prio_accept: got data/inst addr_ok=%b exp 10", {data_sram_addr_ok, inst_sram_addr_ok});
    else passed++;
    cyc();
    data_sram_req = 1'b0;
    arready = 1'b1;
    smp();
    total++;
    if ({arvalid, arid, araddr, arsize, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h200, 3'd1, 1'b0})
      $display("FAIL prio_ar: got v=%b id=%h addr=%h size=%h inst_ok=%b exp 1 1 200 1 0",
               arvalid, arid, araddr, arsize, inst_sram_addr_ok);
    else passed++;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd1;
    rdata = 32'hdead_beef;
    smp();
    total++;
    if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok, data_sram_rdata}
        !== {3'b100, 32'hdead_beef})
      $display("FAIL prio_r: got dok=%b iok=%b iaok=%b rdata=%h exp 1 0 0 deadbeef",
               data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok, data_sram_rdata);
    else passed++;
    cyc();
    rvalid = 1'b0;
    smp();
    total++;
    if (inst_sram_addr_ok !== 1'b1)
      $display("FAIL prio_fetch_late: got %b exp 1", inst_sram_addr_ok);
    else passed++;
    cyc();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    smp();
    total++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1c00_0004})
      $display("FAIL prio_fetch_ar: got v=%b id=%h addr=%h exp 1 0 1c000004", arvalid, arid, araddr);
    else passed++;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd0;
    rdata = 32'h1234_5678;
    smp();
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10)
      $display("FAIL prio_fetch_r: got %b exp 10", {inst_sram_data_ok, data_sram_data_ok});
    else passed++;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_write();
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd0;
    data_sram_addr  = 32'h0000_0010;
    data_sram_wstrb = 4'h2;
    data_sram_wdata = 32'h0000_ab00;
    smp();
    total++;
    if (data_sram_addr_ok !== 1'b1)
      $display("FAIL wr_accept: got %b exp 1", data_sram_addr_ok);
    else passed++;
    cyc();
    idle_inputs();
    wready = 1'b1;
    smp();
    total++;
    if ({awvalid, wvalid, bready, awaddr, awsize, wstrb, wdata}
        !== {3'b110, 32'h10, 3'd0, 4'h2, 32'h0000_ab00})
      $display("FAIL wr_c1: got aw=%b w=%b b=%b addr=%h size=%h strb=%h data=%h exp 1 1 0 10 0 2 0000ab00",
               awvalid, wvalid, bready, awaddr, awsize, wstrb, wdata);
    else passed++;
    cyc();
    wready = 1'b0;
    smp();
    total++;
    if ({awvalid, wvalid, bready} !== 3'b100)
      $display("FAIL wr_c2: got aw/w/b=%b exp 100", {awvalid, wvalid, bready});
    else passed++;
    cyc();
    awready = 1'b1;
    smp();
    total++;
    if ({awvalid, wvalid, bready} !== 3'b100)
      $display("FAIL wr_c3: got aw/w/b=%b exp 100", {awvalid, wvalid, bready});
    else passed++;
    cyc();
    awready = 1'b0;
    smp();
    total++;
    if ({awvalid, wvalid, bready, data_sram_data_ok} !== 4'b0010)
      $display("FAIL wr_resp_wait: got aw/w/b/dok=%b exp 0010", {awvalid, wvalid, bready, data_sram_data_ok});
    else passed++;
    cyc();
    bvalid = 1'b1;
    smp();
    total++;
    if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10)
      $display("FAIL wr_bresp: got dok/iok=%b exp 10", {data_sram_data_ok, inst_sram_data_ok});
    else passed++;
    cyc();
    bvalid = 1'b0;
    smp();
    total++;
    if ({bready, data_sram_data_ok} !== 2'b00)
      $display("FAIL wr_done: got bready/dok=%b exp 00", {bready, data_sram_data_ok});
    else passed++;
    cyc();
  endtask

  task automatic test_write_read_hazard();
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b1;
    data_sram_size = 2'd2;
    data_sram_addr = 32'h0000_0020;
    data_sram_wstrb = 4'hf;
    data_sram_wdata = 32'hcafe_f00d;
    cyc();
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h0000_0030;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0008;
    awready = 1'b1;
    wready  = 1'b1;
    smp();
    total++;
    if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b01)
      $display("FAIL haz_c1: got data/inst addr_ok=%b exp 01", {data_sram_addr_ok, inst_sram_addr_ok});
    else passed++;
    cyc();
    inst_sram_req = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b1;
    smp();
    total++;
    if ({data_sram_addr_ok, arvalid, bready, araddr} !== {3'b011, 32'h1c00_0008})
      $display("FAIL haz_c2: got daok=%b arv=%b bready=%b araddr=%h exp 0 1 1 1c000008",
               data_sram_addr_ok, arvalid, bready, araddr);
    else passed++;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd0;
    smp();
    total++;
    if ({inst_sram_data_ok, data_sram_addr_ok} !== 2'b10)
      $display("FAIL haz_fetch_r: got iok/daok=%b exp 10", {inst_sram_data_ok, data_sram_addr_ok});
    else passed++;
    cyc();
    rvalid = 1'b0;
    bvalid = 1'b1;
    smp();
    total++;
    if ({data_sram_data_ok, data_sram_addr_ok} !== 2'b10)
      $display("FAIL haz_bresp: got dok/daok=%b exp 10", {data_sram_data_ok, data_sram_addr_ok});
    else passed++;
    cyc();
    bvalid = 1'b0;
    smp();
    total++;
    if (data_sram_addr_ok !== 1'b1)
      $display("FAIL haz_read_accept: got %b exp 1", data_sram_addr_ok);
    else passed++;
    cyc();
    data_sram_req = 1'b0;
    arready = 1'b1;
    smp();
    total++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h30})
      $display("FAIL haz_read_ar: got v=%b id=%h addr=%h exp 1 1 30", arvalid, arid, araddr);
    else passed++;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd1;
    rdata = 32'h0bad_cafe;
    smp();
    total++;
    if ({data_sram_data_ok, data_sram_rdata} !== {1'b1, 32'h0bad_cafe})
      $display("FAIL haz_read_r: got dok=%b rdata=%h exp 1 0badcafe", data_sram_data_ok, data_sram_rdata);
    else passed++;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_back_to_back();
    // A write and a fetch launch together; R and B complete in the same cycle.
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b1;
    data_sram_size = 2'd2;
    data_sram_addr = 32'h0000_0040;
    data_sram_wstrb = 4'hc;
    data_sram_wdata = 32'h5555_aaaa;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_000c;
    smp();
    total++;
    if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b11)
      $display("FAIL b2b_accept: got data/inst addr_ok=%b exp 11", {data_sram_addr_ok, inst_sram_addr_ok});
    else passed++;
    cyc();
    idle_inputs();
    arready = 1'b1;
    awready = 1'b1;
    wready  = 1'b1;
    smp();
    total++;
    if ({arvalid, awvalid, wvalid, araddr, awaddr} !== {3'b111, 32'h1c00_000c, 32'h40})
      $display("FAIL b2b_launch: got ar/aw/w=%b araddr=%h awaddr=%h exp 111 1c00000c 40",
               {arvalid, awvalid, wvalid}, araddr, awaddr);
    else passed++;
    cyc();
    idle_inputs();
    rvalid = 1'b1;
    rid = 4'd0;
    bvalid = 1'b1;
    smp();
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok, rready, bready} !== 4'b1111)
      $display("FAIL b2b_complete: got iok/dok/rready/bready=%b exp 1111",
               {inst_sram_data_ok, data_sram_data_ok, rready, bready});
    else passed++;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0010;
    cyc();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    resetn  = 1'b0;
    smp();
    total++;
    if ({rready, inst_sram_data_ok} !== 2'b10)
      $display("FAIL rst_mid_wait: got rready/iok=%b exp 10", {rready, inst_sram_data_ok});
    else passed++;
    cyc();
    resetn = 1'b1;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0020;
    smp();
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, araddr} !== {5'b0, 32'h0})
      $display("FAIL rst_mid_clear: got valids=%b araddr=%h exp 00000 0",
               {arvalid, rready, awvalid, wvalid, bready}, araddr);
    else passed++;
    total++;
    if (inst_sram_addr_ok !== 1'b1)
      $display("FAIL rst_mid_reaccept: got %b exp 1", inst_sram_addr_ok);
    else passed++;
    cyc();
    inst_sram_req = 1'b0;
    smp();
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h1c00_0020})
      $display("FAIL rst_mid_ar: got v=%b addr=%h exp 1 1c000020", arvalid, araddr);
    else passed++;
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd0;
    cyc();
    idle_inputs();
    cyc();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_fetch();
    test_read_priority();
    test_write();
    test_write_read_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
